// File: rtl/mask_merge_pkg.sv
// ----------------------------------------------------------------------------
// mask_merge_pkg
// Shared constants, width helper and lane index type for the mask lane merger.
//   LANE_W(n)    : index width for n items, never less than 1 bit
//   N_LANES_DEF  : default number of mask-calculation lanes
//   MASK_W       : beat width for a binary mask
//   RGB_W        : beat width for RGB pass-through
//   lane_idx_t   : lane index wide enough for the maximum of 16 lanes
// ----------------------------------------------------------------------------
package mask_merge_pkg;

    localparam int N_LANES_DEF = 4;
    localparam int MASK_W      = 1;
    localparam int RGB_W       = 24;

    // $clog2(1) is 0, which would give a zero-width vector.
    function automatic int LANE_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [3:0] lane_idx_t;

endpackage

// File: rtl/lane_fifo.sv
// ----------------------------------------------------------------------------
// lane_fifo
// Synchronous FIFO buffering one mask lane. A write is accepted when the FIFO
// is not full, or when it is full but a pop happens in the same cycle.
// i_CLR empties the FIFO and discards the write of that cycle.
// Ports:
//   i_CLK, i_RSTn  clock, asynchronous active-low reset
//   i_CLR          synchronous flush
//   i_WR, i_WDATA  write strobe and data
//   i_RD           pop request (ignored while empty)
//   o_RDATA        head of the FIFO (valid while !o_EMPTY)
//   o_FULL         FIFO holds FIFO_DEPTH entries
//   o_EMPTY        FIFO holds no entry
// ----------------------------------------------------------------------------
module lane_fifo
    import mask_merge_pkg::*;
#(
    parameter int DATA_WIDTH = MASK_W,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  i_CLK,
    input  logic                  i_RSTn,
    input  logic                  i_CLR,
    input  logic                  i_WR,
    input  logic [DATA_WIDTH-1:0] i_WDATA,
    input  logic                  i_RD,
    output logic [DATA_WIDTH-1:0] o_RDATA,
    output logic                  o_FULL,
    output logic                  o_EMPTY
);

    localparam int AW = LANE_W(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;
    logic                  w_do_rd;
    logic                  w_do_wr;

    assign o_FULL  = (r_count == (AW+1)'(FIFO_DEPTH));
    assign o_EMPTY = (r_count == '0);
    assign o_RDATA = r_mem[r_rd_ptr];

    assign w_do_rd = i_RD & ~o_EMPTY;
    // A pop frees the slot the write lands in, so a full FIFO still accepts.
    assign w_do_wr = i_WR & (~o_FULL | w_do_rd);

    // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
    always_ff @(posedge i_CLK) begin
        if (w_do_wr && !i_CLR) begin
            r_mem[r_wr_ptr] <= i_WDATA;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_CLR) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_do_wr) - (AW+1)'(w_do_rd);
        end
    end

endmodule

// File: rtl/mask_lane_merge.sv
// ----------------------------------------------------------------------------
// mask_lane_merge
// Merges N_LANES parallel mask lanes into one in-order pixel stream. Lane k
// carries pixels k, k+N, k+2N, ...; each lane is buffered in its own FIFO and
// beats are emitted strictly in lane order 0..N_LANES-1, waiting on an empty
// lane rather than skipping it.
// Optional feature macro: MASK_MERGE_EOL_EN enables a column counter and o_EOL
// on the last beat of each LINE_WIDTH-beat line; otherwise o_EOL is 0.
// Ports:
//   i_CLK, i_RSTn  clock, asynchronous active-low reset
//   i_CLR          synchronous flush (FIFOs, lane select, output, flags, column)
//   i_VALID        per-lane write strobe
//   i_DATA         lane k at bits [k*DATA_WIDTH +: DATA_WIDTH]
//   i_READY        downstream accepts the current beat
//   o_VALID/o_DATA registered output beat, held while stalled
//   o_LANE         source lane of o_DATA
//   o_OVF          sticky per-lane overflow (write dropped on a full FIFO)
//   o_EOL          last beat of the line
// ----------------------------------------------------------------------------
module mask_lane_merge
    import mask_merge_pkg::*;
#(
    parameter int N_LANES    = N_LANES_DEF,
    parameter int DATA_WIDTH = MASK_W,
    parameter int FIFO_DEPTH = 8,
    parameter int LINE_WIDTH = 640
) (
    input  logic                            i_CLK,
    input  logic                            i_RSTn,
    input  logic                            i_CLR,
    input  logic [N_LANES-1:0]              i_VALID,
    input  logic [N_LANES*DATA_WIDTH-1:0]   i_DATA,
    input  logic                            i_READY,
    output logic                            o_VALID,
    output logic [DATA_WIDTH-1:0]           o_DATA,
    output logic [LANE_W(N_LANES)-1:0]      o_LANE,
    output logic [N_LANES-1:0]              o_OVF,
    output logic                            o_EOL
);

    localparam int LW = LANE_W(N_LANES);

    logic [DATA_WIDTH-1:0] w_rdata [N_LANES];
    logic [N_LANES-1:0]    w_full;
    logic [N_LANES-1:0]    w_empty;
    logic [N_LANES-1:0]    w_pop;
    logic                  w_load;
    logic [LW-1:0]         w_sel_next;

    logic [LW-1:0]         r_sel;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [LW-1:0]         r_lane;
    logic [N_LANES-1:0]    r_ovf;

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        lane_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .i_CLK   (i_CLK),
            .i_RSTn  (i_RSTn),
            .i_CLR   (i_CLR),
            .i_WR    (i_VALID[g]),
            .i_WDATA (i_DATA[g*DATA_WIDTH +: DATA_WIDTH]),
            .i_RD    (w_pop[g]),
            .o_RDATA (w_rdata[g]),
            .o_FULL  (w_full[g]),
            .o_EMPTY (w_empty[g])
        );
    end

    // The output register is free when empty or being accepted this cycle.
    assign w_load = (~r_valid | i_READY) & ~w_empty[r_sel];

    // N_LANES need not be a power of 2, so sel wraps explicitly.
    assign w_sel_next = (r_sel == LW'(N_LANES - 1)) ? '0 : r_sel + 1'b1;

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        w_pop = '0;
        for (int k = 0; k < N_LANES; k++) begin
            w_pop[k] = w_load & (r_sel == LW'(k));
        end
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_lane  <= '0;
            r_ovf   <= '0;
        end else if (i_CLR) begin
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_lane  <= '0;
            r_ovf   <= '0;
        end else begin
            // Dropped write: FIFO full and not being popped in the same cycle.
            r_ovf <= r_ovf | (i_VALID & w_full & ~w_pop);
            if (w_load) begin
                r_valid <= 1'b1;
                r_data  <= w_rdata[r_sel];
                r_lane  <= r_sel;
                r_sel   <= w_sel_next;
            end else if (i_READY) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef MASK_MERGE_EOL_EN
    localparam int CW = LANE_W(LINE_WIDTH);

    logic [CW-1:0] r_col;
    logic          r_eol;

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            r_col <= '0;
            r_eol <= 1'b0;
        end else if (i_CLR) begin
            r_col <= '0;
            r_eol <= 1'b0;
        end else if (w_load) begin
            // o_EOL travels with the beat and is held with it while stalled.
            r_eol <= (r_col == CW'(LINE_WIDTH - 1));
            r_col <= (r_col == CW'(LINE_WIDTH - 1)) ? '0 : r_col + 1'b1;
        end
    end

    assign o_EOL = r_eol;
`else
    assign o_EOL = 1'b0;
`endif

    assign o_VALID = r_valid;
    assign o_DATA  = r_data;
    assign o_LANE  = r_lane;
    assign o_OVF   = r_ovf;

endmodule
